// File: rtl/jam_cost_table.sv
// jam_cost_table: 8x8 worker/job cost table for the JAM core, loaded serially.
// The COST_ACCESS_CNT_EN macro adds the 24-bit saturating ACCESS_CNT output.
module jam_cost_table #(
    parameter int COST_W = 7,
    parameter int IDX_W  = 3
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              LOAD_START,
    input  logic              LOAD_VALID,
    input  logic [COST_W-1:0] LOAD_DATA,
    output logic              LOAD_READY,
    output logic              TABLE_READY,
    input  logic [IDX_W-1:0]  W,
    input  logic [IDX_W-1:0]  J,
`ifdef COST_ACCESS_CNT_EN
    output logic [23:0]       ACCESS_CNT,
`endif
    output logic [COST_W-1:0] Cost
);

    localparam int PTR_W = 2 * IDX_W;
    localparam int DEPTH = 1 << PTR_W;

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_LOADING = 2'd1,
        S_READY   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [COST_W-1:0] cost_q, cost_d;
    logic              wr_en;

    logic [COST_W-1:0] mem_q [DEPTH];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_EMPTY;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // LOAD_START outranks a same-cycle data beat, which is dropped.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wr_en   = 1'b0;
        unique case (state_q)
            S_EMPTY: begin
                if (LOAD_START) begin
                    state_d = S_LOADING;
                    ptr_d   = '0;
                end
            end
            S_LOADING: begin
                if (LOAD_START) begin
                    ptr_d = '0;
                end else if (LOAD_VALID) begin
                    wr_en = 1'b1;
                    ptr_d = ptr_q + 1'b1;
                    if (ptr_q == {PTR_W{1'b1}}) begin
                        state_d = S_READY;
                    end
                end
            end
            S_READY: begin
                if (LOAD_START) begin
                    state_d = S_LOADING;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = S_EMPTY;
                ptr_d   = '0;
            end
        endcase
    end

    always_comb begin
        LOAD_READY  = (state_q == S_LOADING);
        TABLE_READY = (state_q == S_READY);
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[ptr_q] <= LOAD_DATA;
        end
    end

    always_comb begin
        cost_d = '0;
        if (state_q == S_READY) begin
            cost_d = mem_q[{W, J}];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cost_q <= '0;
        end else begin
            cost_q <= cost_d;
        end
    end

    assign Cost = cost_q;

`ifdef COST_ACCESS_CNT_EN
    logic [23:0] acc_q, acc_d;

    always_comb begin
        acc_d = acc_q;
        if (LOAD_START) begin
            acc_d = '0;
        end else if (state_q == S_READY && acc_q != 24'hFF_FFFF) begin
            acc_d = acc_q + 24'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign ACCESS_CNT = acc_q;
`endif

endmodule

// File: tb/tb_jam_cost_table.sv
// tb_jam_cost_table: vector table, directed load sequences and random traffic
// checked against a transaction-level table model.
module tb_jam_cost_table;

    localparam int COST_W = 7;
    localparam int IDX_W  = 3;
    localparam int N      = 64;
    localparam int M_EMPTY = 0;
    localparam int M_LOAD  = 1;
    localparam int M_READY = 2;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic              LOAD_START = 1'b0;
    logic              LOAD_VALID = 1'b0;
    logic [COST_W-1:0] LOAD_DATA = '0;
    logic              LOAD_READY;
    logic              TABLE_READY;
    logic [IDX_W-1:0]  W = '0;
    logic [IDX_W-1:0]  J = '0;
    logic [COST_W-1:0] Cost;
`ifdef COST_ACCESS_CNT_EN
    logic [23:0]       ACCESS_CNT;
`endif

    jam_cost_table #(.COST_W(COST_W), .IDX_W(IDX_W)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .LOAD_START (LOAD_START),
        .LOAD_VALID (LOAD_VALID),
        .LOAD_DATA  (LOAD_DATA),
        .LOAD_READY (LOAD_READY),
        .TABLE_READY(TABLE_READY),
        .W          (W),
        .J          (J),
`ifdef COST_ACCESS_CNT_EN
        .ACCESS_CNT (ACCESS_CNT),
`endif
        .Cost       (Cost)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    // Reference model: a plain table plus a count of beats taken in this load.
    int m_tbl [N];
    int m_mode  = M_EMPTY;
    int m_beats = 0;
    int m_cost  = 0;
    int m_acc   = 0;

    typedef struct {
        int w;
        int j;
        int cost;
    } rd_vec_t;

    rd_vec_t vecs [6];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit st, input bit vl, input int d,
                        input int w, input int j);
        LOAD_START = st;
        LOAD_VALID = vl;
        LOAD_DATA  = d[COST_W-1:0];
        W          = w[IDX_W-1:0];
        J          = j[IDX_W-1:0];
        @(posedge CLK);
        #1;
        m_cost = (m_mode == M_READY) ? m_tbl[w * 8 + j] : 0;
        if (st) m_acc = 0;
        else if (m_mode == M_READY && m_acc < 'hFFFFFF) m_acc++;
        if (st) begin
            m_mode  = M_LOAD;
            m_beats = 0;
        end else if (m_mode == M_LOAD && vl) begin
            m_tbl[m_beats] = d % 128;
            m_beats++;
            if (m_beats == N) m_mode = M_READY;
        end
        chk("load_ready", int'(LOAD_READY), int'(m_mode == M_LOAD));
        chk("table_ready", int'(TABLE_READY), int'(m_mode == M_READY));
        chk("cost", int'(Cost), m_cost);
`ifdef COST_ACCESS_CNT_EN
        chk("access_cnt", int'(ACCESS_CNT), m_acc);
`endif
    endtask

    task automatic do_reset();
        LOAD_START = 1'b0;
        LOAD_VALID = 1'b0;
        RST_N = 1'b0;
        #2;
        chk("rst_load_ready", int'(LOAD_READY), 0);
        chk("rst_table_ready", int'(TABLE_READY), 0);
        chk("rst_cost", int'(Cost), 0);
        m_mode  = M_EMPTY;
        m_beats = 0;
        m_cost  = 0;
        m_acc   = 0;
        #2;
        RST_N = 1'b1;
    endtask

    task automatic sweep();
        for (int i = 0; i < N; i++) step(0, 0, 0, i / 8, i % 8);
        step(0, 0, 0, 0, 0);
    endtask

    initial begin
        vecs[0] = '{3, 5, 29};
        vecs[1] = '{7, 7, 63};
        vecs[2] = '{0, 0, 0};
        vecs[3] = '{1, 2, 10};
        vecs[4] = '{6, 3, 51};
        vecs[5] = '{4, 7, 39};

        @(posedge CLK);
        #1;
        do_reset();

        // Idle after reset
        for (int i = 0; i < 5; i++) step(0, 0, 0, i % 8, 7 - i);

        // Load index % 100 with LOAD_VALID held high
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < N; i++) begin
            step(0, 1, i % 100, 0, 0);
            if (i < N - 1) chk("tr_low_mid_load", int'(TABLE_READY), 0);
        end
        chk("tr_after_64", int'(TABLE_READY), 1);
        for (int v = 0; v < 6; v++) begin
            step(0, 0, 0, vecs[v].w, vecs[v].j);
            chk($sformatf("vec%0d", v), int'(Cost), vecs[v].cost);
        end

`ifdef COST_ACCESS_CNT_EN
        begin
            int base;
            base = m_acc;
            for (int i = base; i < 100; i++) step(0, 0, 0, i % 8, 0);
            chk("acc_100", int'(ACCESS_CNT), 100);
            step(1, 0, 0, 0, 0);
            chk("acc_clear", int'(ACCESS_CNT), 0);
        end
`endif

        // Toggling LOAD_VALID load with random data, then full sweep
        begin
            int rise;
            rise = -1;
            step(1, 0, 0, 0, 0);
            for (int k = 1; k <= 2 * N; k++) begin
                step(0, (k % 2) == 1, int'($urandom_range(127)),
                     int'($urandom_range(7)), int'($urandom_range(7)));
                if (rise < 0 && TABLE_READY) rise = k;
            end
            chk("toggle_ready_cycle", rise, 2 * N - 1);
            sweep();
        end

        // Restart after 20 beats; the colliding 99 beat is dropped
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 7, 0, 0);
        step(1, 1, 99, 0, 0);
        for (int i = 0; i < N; i++) step(0, 1, 5, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("restart_w0j0", int'(Cost), 5);
        for (int i = 0; i < N; i++) begin
            step(0, 0, 0, i / 8, i % 8);
            chk("restart_all5", int'(Cost), 5);
        end

        // Reset at beat 40 of a load
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) step(0, 1, 1, 0, 0);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 3, 5);
            chk("post_rst_cost", int'(Cost), 0);
        end
        for (int i = 0; i < N; i++) step(0, 1, 9, 2, 2);
        chk("valid_no_start_ignored", int'(TABLE_READY), 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < N; i++) step(0, 1, (i * 3) % 128, 0, 0);
        chk("reload_ready", int'(TABLE_READY), 1);
        sweep();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(599) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(63) == 0, $urandom_range(1) == 1,
                     int'($urandom_range(127)),
                     int'($urandom_range(7)), int'($urandom_range(7)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
